// File: rtl/cache_mem_responder_if.sv
// Cache mem_* port bundle: request/write-data from the cache (master), refill beats and write response from memory (slave).
interface cache_mem_responder_if #(
   parameter int BUS_WIDTH  = 32,
   parameter int DATA_WIDTH = 32
);
   logic                      mem_ce;
   logic                      mem_we;
   logic [BUS_WIDTH-1:0]      mem_addr;
   logic [DATA_WIDTH-1:0]     mem_wdata;
   logic [DATA_WIDTH/8-1:0]   mem_wmask;
   logic [DATA_WIDTH-1:0]     mem_rdata;
   logic                      mem_rdata_valid;
   logic                      mem_write_respone;

   modport master (
      output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
      input  mem_rdata, mem_rdata_valid, mem_write_respone
   );

   modport slave (
      input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask,
      output mem_rdata, mem_rdata_valid, mem_write_respone
   );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache mem_* port: line refill bursts and masked single-word writes from a word array.
// First beat / write response LATENCY+1 cycles after acceptance; one request at a time, burst is never stalled.
module cache_mem_responder #(
   parameter int BUS_WIDTH  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int MEM_DEPTH  = 1024,
   parameter int LATENCY    = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   cache_mem_responder_if.slave mem
);

   localparam int IDX_W  = $clog2(MEM_DEPTH);
   localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int NB     = DATA_WIDTH / 8;
   localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [IDX_W-1:0]  LINE_MASK = ~IDX_W'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_BURST,
      S_WRESP,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [LAT_W-1:0]        lat_cnt_q, lat_cnt_d;
   logic [BEAT_W-1:0]       beat_q, beat_d;
   logic [IDX_W-1:0]        base_q, base_d;
   logic                    we_q, we_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    rvld_q, rvld_d;
   logic                    wresp_q, wresp_d;

   logic [DATA_WIDTH-1:0]   store_q [MEM_DEPTH];

   logic [IDX_W-1:0]        idx;
   logic                    accept;
   logic                    wr_en;
   logic                    unused_addr;

   // Upper address bits alias and the byte offset is dropped.
   assign idx         = mem.mem_addr[IDX_W+1:2];
   assign unused_addr = ^mem.mem_addr;
   assign accept      = (state_q == S_IDLE) && mem.mem_ce;
   assign wr_en       = accept && mem.mem_we && !reset;

   always_comb begin
      state_d   = state_q;
      lat_cnt_d = lat_cnt_q;
      beat_d    = beat_q;
      base_d    = base_q;
      we_d      = we_q;
      rdata_d   = '0;
      rvld_d    = 1'b0;
      wresp_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem.mem_ce) begin
               base_d    = idx & LINE_MASK;
               we_d      = mem.mem_we;
               beat_d    = '0;
               lat_cnt_d = LAT_INIT;
               if (LATENCY == 0) begin
                  state_d = mem.mem_we ? S_WRESP : S_BURST;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (lat_cnt_q == '0) begin
               state_d = we_q ? S_WRESP : S_BURST;
            end else begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end
         end
         S_BURST: begin
            rvld_d  = 1'b1;
            rdata_d = store_q[base_q | IDX_W'(beat_q)];
            beat_d  = beat_q + 1'b1;
            if (beat_q == LAST_BEAT) begin
               state_d = S_DONE;
            end
         end
         S_WRESP: begin
            wresp_d = 1'b1;
            state_d = S_DONE;
         end
         // Dead cycle so a registered mem_ce from the cache can drop.
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         lat_cnt_q <= '0;
         beat_q    <= '0;
         base_q    <= '0;
         we_q      <= 1'b0;
         rdata_q   <= '0;
         rvld_q    <= 1'b0;
         wresp_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         lat_cnt_q <= lat_cnt_d;
         beat_q    <= beat_d;
         base_q    <= base_d;
         we_q      <= we_d;
         rdata_q   <= rdata_d;
         rvld_q    <= rvld_d;
         wresp_q   <= wresp_d;
      end
   end

   // The write lands on the acceptance edge; the response only reports it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (mem.mem_wmask[b]) begin
               store_q[idx][b*8 +: 8] <= mem.mem_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign mem.mem_rdata         = rdata_q;
   assign mem.mem_rdata_valid   = rvld_q;
   assign mem.mem_write_respone = wresp_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized bench for cache_mem_responder: a LATENCY=2 and a LATENCY=0 instance checked cycle by cycle against a word-array model.
module tb_cache_mem_responder;

   localparam int BL    = 16;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   always #5 clk = ~clk;

   logic        ce = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wmask = '0;
   int          sel = 0;
   int          lat = 2;
   bit          noise = 1'b0;

   cache_mem_responder_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) if2 ();
   cache_mem_responder_if #(.BUS_WIDTH(32), .DATA_WIDTH(32)) if0 ();

   cache_mem_responder #(.LATENCY(2)) u_dut2 (.clk(clk), .reset(reset), .mem(if2.slave));
   cache_mem_responder #(.LATENCY(0)) u_dut0 (.clk(clk), .reset(reset), .mem(if0.slave));

   assign if2.mem_ce    = ce && (sel == 0);
   assign if2.mem_we    = we;
   assign if2.mem_addr  = addr;
   assign if2.mem_wdata = wdata;
   assign if2.mem_wmask = wmask;
   assign if0.mem_ce    = ce && (sel == 1);
   assign if0.mem_we    = we;
   assign if0.mem_addr  = addr;
   assign if0.mem_wdata = wdata;
   assign if0.mem_wmask = wmask;

   logic        obs_vld, obs_rsp;
   logic [31:0] obs_dat;
   assign obs_vld = (sel == 0) ? if2.mem_rdata_valid   : if0.mem_rdata_valid;
   assign obs_rsp = (sel == 0) ? if2.mem_write_respone : if0.mem_write_respone;
   assign obs_dat = (sel == 0) ? if2.mem_rdata         : if0.mem_rdata;

   logic [31:0] ref_mem [2][DEPTH];
   logic [31:0] beats [BL];
   int          n_chk = 0;
   int          n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int word_idx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   task automatic drive_noise();
      if (noise) begin
         ce    = 1'($urandom_range(0, 1));
         we    = 1'($urandom_range(0, 1));
         addr  = $urandom;
         wdata = $urandom;
         wmask = 4'($urandom);
      end
   endtask

   task automatic wr_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int i;
      i = word_idx(a);
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = a; wdata = d; wmask = m;
      for (int b = 0; b < 4; b++)
         if (m[b]) ref_mem[sel][i][b*8 +: 8] = d[b*8 +: 8];
      @(posedge clk);
      for (int c = 1; c <= lat + 2; c++) begin
         @(negedge clk); drive_noise();
         @(posedge clk); #1;
         chk("wr_resp", 32'(obs_rsp), 32'(c == lat + 1));
         chk("wr_no_valid", 32'(obs_vld), 32'd0);
      end
      @(negedge clk); ce = 1'b0;
   endtask

   task automatic rd_txn(input logic [31:0] a);
      int base, k;
      base = (word_idx(a) / BL) * BL;
      @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = a; wdata = $urandom; wmask = 4'($urandom);
      @(posedge clk);
      for (int c = 1; c <= lat + BL + 1; c++) begin
         @(negedge clk); drive_noise();
         @(posedge clk); #1;
         k = c - lat - 1;
         if (k >= 0 && k < BL) begin
            beats[k] = obs_dat;
            chk("rd_valid", 32'(obs_vld), 32'd1);
            chk("rd_data", obs_dat, ref_mem[sel][base + k]);
         end else begin
            chk("rd_idle_valid", 32'(obs_vld), 32'd0);
            chk("rd_idle_data", obs_dat, 32'd0);
         end
         chk("rd_no_resp", 32'(obs_rsp), 32'd0);
      end
      @(negedge clk); ce = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      int          phase;
      bit          exp_v;

      // Asynchronous reset asserted mid-cycle
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("rst_valid2", 32'(if2.mem_rdata_valid), 32'd0);
      chk("rst_resp2", 32'(if2.mem_write_respone), 32'd0);
      chk("rst_data2", if2.mem_rdata, 32'd0);
      chk("rst_valid0", 32'(if0.mem_rdata_valid), 32'd0);
      chk("rst_resp0", 32'(if0.mem_write_respone), 32'd0);
      chk("rst_data0", if0.mem_rdata, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;

      sel = 0; lat = 2; noise = 1'b0;
      for (int i = 0; i < 128; i++) wr_txn(32'(i * 4), $urandom, 4'hF);

      // Line refill at a mid-line address
      for (int k = 0; k < BL; k++) wr_txn(32'((16 + k) * 4), 32'hA000_0000 + 32'(k), 4'hF);
      rd_txn(32'h48);
      for (int k = 0; k < BL; k++) chk("line1_beat", beats[k], 32'hA000_0000 + 32'(k));

      // Byte-masked write and an all-zero mask
      wr_txn(32'h14, 32'h1122_3344, 4'hF);
      wr_txn(32'h14, 32'hAABB_CCDD, 4'b0101);
      rd_txn(32'h0);
      chk("masked_word", beats[5], 32'h11BB_33DD);
      wr_txn(32'h14, 32'hFFFF_FFFF, 4'b0000);
      rd_txn(32'h0);
      chk("zero_mask_word", beats[5], 32'h11BB_33DD);

      // Aliased write, inputs toggling while busy
      noise = 1'b1;
      wr_txn(32'h1000_0010, 32'hCAFE_F00D, 4'hF);
      rd_txn(32'h10);
      chk("alias_word", beats[4], 32'hCAFE_F00D);

      for (int t = 0; t < 60; t++) begin
         noise = 1'($urandom_range(0, 1));
         a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) wr_txn(a, $urandom, 4'($urandom));
         else rd_txn(a);
      end
      noise = 1'b0;

      // Reset after beat 7 of a burst
      @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = 32'h48;
      @(posedge clk);
      for (int c = 1; c <= lat + 8; c++) begin
         @(posedge clk); #1;
         if (c >= lat + 1) begin
            chk("pre_abort_valid", 32'(obs_vld), 32'd1);
            chk("pre_abort_data", obs_dat, ref_mem[0][16 + c - lat - 1]);
         end
      end
      #2 reset = 1'b1;
      #1;
      chk("abort_valid", 32'(obs_vld), 32'd0);
      chk("abort_data", obs_dat, 32'd0);
      @(negedge clk);
      ce = 1'b0; reset = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("post_abort_valid", 32'(obs_vld), 32'd0);
      end
      rd_txn(32'h48);

      // Reset during the wait of a write: data stays committed, no response
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5A5A_0FF0; wmask = 4'hF;
      ref_mem[0][8] = 32'h5A5A_0FF0;
      @(posedge clk);
      @(posedge clk); #1;
      #2 reset = 1'b1;
      #1;
      chk("wabort_resp", 32'(obs_rsp), 32'd0);
      @(negedge clk);
      ce = 1'b0; reset = 1'b0;
      for (int c = 0; c < lat + 3; c++) begin
         @(posedge clk); #1;
         chk("wabort_no_resp", 32'(obs_rsp), 32'd0);
      end
      rd_txn(32'h20);
      chk("wabort_committed", beats[8], 32'h5A5A_0FF0);

      // Zero latency, mem_ce held high across two back-to-back reads
      sel = 1; lat = 0;
      for (int k = 0; k < BL; k++) wr_txn(32'(k * 4), $urandom, 4'hF);
      @(negedge clk);
      ce = 1'b1; we = 1'b0; addr = 32'h8;
      @(posedge clk);
      for (int c = 1; c <= 37; c++) begin
         @(negedge clk);
         if (c == 36) ce = 1'b0;
         @(posedge clk); #1;
         phase = (c - 1) % (BL + 2);
         exp_v = (c <= 2 * (BL + 2) - 2) && (phase < BL);
         chk("b2b_valid", 32'(obs_vld), 32'(exp_v));
         chk("b2b_data", obs_dat, exp_v ? ref_mem[1][phase] : 32'd0);
         chk("b2b_no_resp", 32'(obs_rsp), 32'd0);
      end
      rd_txn(32'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
